// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_W         = 8;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LANE_W         = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // True in the states where the loader consumes stream bytes.
  function automatic logic in_session(input state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shift register with a registered word-complete pulse.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_complete
);

  logic [LANE_W-1:0] byte_idx;

  // Shift each byte in from the top so the first byte lands in bits [7:0].
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_out      <= '0;
      byte_idx      <= '0;
      word_complete <= 1'b0;
    end else begin
      word_complete <= 1'b0;
      if (clear) begin
        word_out <= '0;
        byte_idx <= '0;
      end else if (shift_en) begin
        word_out      <= {byte_in, word_out[WORD_W-1:BYTE_W]};
        byte_idx      <= byte_idx + LANE_W'(1);
        word_complete <= (byte_idx == LANE_W'(BYTES_PER_WORD - 1));
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and releases the CPU from reset only after a clean load.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   len_lo_q;
  logic [LEN_W-1:0]    len_total_q;
  logic [LEN_W-1:0]    word_cnt_q;
  logic [LANE_W-1:0]   lane_q;
  logic [CSUM_W-1:0]   csum_q;

  logic                accept_c;
  logic [LEN_W-1:0]    length_c;
  logic                last_byte_c;
  logic                word_end_c;
  logic                enter_len_lo_c;

  assign accept_c       = byte_valid & byte_ready;
  assign length_c       = {byte_data, len_lo_q};
  assign word_end_c     = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign last_byte_c    = word_end_c && (word_cnt_q == len_total_q - LEN_W'(1));
  assign enter_len_lo_c = (state_d == S_LEN_LO) && (state_q != S_LEN_LO);

  // Word assembly and the write strobe/data it produces.
  word_assembler u_asm (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (enter_len_lo_c),
    .shift_en      (accept_c && (state_q == S_DATA)),
    .byte_in       (byte_data),
    .word_out      (mem_wdata),
    .word_complete (mem_we)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; start only matters when no session is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept_c) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept_c) begin
          if (length_c == '0)                     state_d = S_CHECK;
          else if (32'(length_c) > DEPTH_WORDS)   state_d = S_ERROR;
          else                                    state_d = S_DATA;
        end
      end
      S_DATA:  if (accept_c && last_byte_c) state_d = S_CHECK;
      S_CHECK: begin
        if (accept_c) state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      byte_ready <= in_session(state_d);
      busy       <= in_session(state_d);
      done       <= (state_d == S_DONE);
      error      <= (state_d == S_ERROR);
      cpu_reset  <= (state_d != S_DONE);
    end
  end

  // Length capture, word/lane counting, checksum and write address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_lo_q    <= '0;
      len_total_q <= '0;
      word_cnt_q  <= '0;
      lane_q      <= '0;
      csum_q      <= '0;
      mem_addr    <= '0;
    end else if (enter_len_lo_c) begin
      word_cnt_q <= '0;
      lane_q     <= '0;
      csum_q     <= '0;
    end else if (accept_c) begin
      case (state_q)
        S_LEN_LO: len_lo_q    <= byte_data;
        S_LEN_HI: len_total_q <= length_c;
        S_DATA: begin
          csum_q <= csum_q ^ byte_data;
          lane_q <= lane_q + LANE_W'(1);
          if (word_end_c) begin
            word_cnt_q <= word_cnt_q + LEN_W'(1);
            mem_addr   <= BASE_ADDR + 32'({word_cnt_q, 2'b00});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued at stimulus
// time and a monitor compares every mem_we pulse against the queue.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic [7:0] good_s[$] = '{8'h02, 8'h00, 8'hB3, 8'h01, 8'h52, 8'h00,
                            8'h33, 8'h02, 8'h52, 8'h40, 8'hC3};
  logic [7:0] bad_s[$]  = '{8'h02, 8'h00, 8'hB3, 8'h01, 8'h52, 8'h00,
                            8'h33, 8'h02, 8'h52, 8'h40, 8'hC2};
  logic [7:0] over_s[$] = '{8'h41, 8'h00};
  logic [7:0] zero_s[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] zbad_s[$] = '{8'h00, 8'h00, 8'h01};

  program_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {done, error, cpu_reset, byte_ready, busy}
  task automatic chk_status(input string name, input logic [4:0] exp);
    chk(name, 32'({done, error, cpu_reset, byte_ready, busy}), 32'(exp));
  endtask

  task automatic push_good_writes();
    exp_q.push_back('{addr: 32'h0000_0000, data: 32'h0052_01B3});
    exp_q.push_back('{addr: 32'h0000_0004, data: 32'h4052_0233});
  endtask

  task automatic pulse_start();
    @(negedge clock);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    bit sent = 1'b0;
    for (int i = 0; i < 100 && !sent; i++) begin
      @(negedge clock);
      if (throttle && ($urandom_range(0, 1) == 0)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        if (byte_ready) begin
          @(posedge clock);
          #1;
          byte_valid = 1'b0;
          sent = 1'b1;
        end
      end
    end
    if (!sent) begin
      checks++;
      errors++;
      byte_valid = 1'b0;
      $display("FAIL byte_accept: byte %h got no acceptance, required within 100 cycles", b);
    end
  endtask

  task automatic send_seq(input logic [7:0] s[$], input bit throttle, input int start_at);
    for (int i = 0; i < s.size(); i++) begin
      if (i == start_at) pulse_start();
      send_byte(s[i], throttle);
    end
  endtask

  task automatic begin_session(input string name);
    pulse_start();
    chk_status(name, 5'b00111);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write %h@%h, required none", mem_wdata, mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", mem_addr, e.addr);
          chk("write_data", mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk_status("reset_status", 5'b00100);
    chk("reset_addr", mem_addr, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_status("idle_status", 5'b00100);

    // Normal load, with a direct check of write timing on word 0.
    push_good_writes();
    begin_session("start_normal");
    for (int i = 0; i < 6; i++) send_byte(good_s[i], 1'b0);
    chk("word0_strobe", 32'({mem_we, mem_addr[7:0]}), 32'h100);
    for (int i = 6; i < good_s.size(); i++) send_byte(good_s[i], 1'b0);
    @(negedge clock);
    chk_status("normal_done", 5'b10000);

    // Bad checksum: words still written, error raised, CPU held.
    push_good_writes();
    begin_session("start_badcsum");
    send_seq(bad_s, 1'b0, -1);
    @(negedge clock);
    chk_status("badcsum_error", 5'b01100);

    // Oversize length: error right after the length bytes, no writes.
    begin_session("start_oversize");
    send_seq(over_s, 1'b0, -1);
    @(negedge clock);
    chk_status("oversize_error", 5'b01100);
    repeat (3) @(negedge clock);
    chk_status("oversize_hold", 5'b01100);

    // Zero length, good and bad checksum.
    begin_session("start_zero");
    send_seq(zero_s, 1'b0, -1);
    @(negedge clock);
    chk_status("zero_done", 5'b10000);
    begin_session("start_zero_bad");
    send_seq(zbad_s, 1'b0, -1);
    @(negedge clock);
    chk_status("zero_bad_error", 5'b01100);

    // Throttled stream with a start pulse mid-session that must be ignored.
    push_good_writes();
    begin_session("start_throttle");
    send_seq(good_s, 1'b1, 5);
    @(negedge clock);
    chk_status("throttle_done", 5'b10000);

    // Asynchronous reset after five data bytes; only word 0 is ever written.
    exp_q.push_back('{addr: 32'h0000_0000, data: 32'h0052_01B3});
    begin_session("start_abort");
    for (int i = 0; i < 7; i++) send_byte(good_s[i], 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_status("async_reset_status", 5'b00100);
    chk("async_reset_we", 32'(mem_we), 32'h0);
    chk("async_reset_addr", mem_addr, 32'h0);
    chk("async_reset_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk_status("after_reset_idle", 5'b00100);

    push_good_writes();
    begin_session("start_reload");
    send_seq(good_s, 1'b0, -1);
    @(negedge clock);
    chk_status("reload_done", 5'b10000);

    repeat (5) @(negedge clock);
    chk("pending_writes", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
